// File: rtl/jk_stim_seq.sv
// jk_stim_seq: stimulus sequencer for JK flip-flop experiments.
// Steps WIDTH j/k channels through HOLD, SET, RESET and TOGGLE, DWELL cycles
// per phase and LOOPS passes per start. It also produces the Q that an ideal
// JK register clocked from j/k would show (q_exp).
module jk_stim_seq #(
  parameter int WIDTH = 4,
  parameter int DWELL = 5,
  parameter int LOOPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_exp,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done
);

  // Counters hold at most DWELL-1 / LOOPS-1; keep them at least one bit wide.
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int LP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [LP_W-1:0] LOOP_LAST  = LP_W'(LOOPS - 1);
  localparam logic [DW_W-1:0] DW_ONE     = DW_W'(1);
  localparam logic [LP_W-1:0] LP_ONE     = LP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_p;
  logic [DW_W-1:0]  r_dwell;
  logic [LP_W-1:0]  r_loop;
  logic             r_mode;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;

  logic                 w_dwell_last;
  logic                 w_toggle_end;
  logic                 w_seq_end;
  logic [1:0]           w_p_next;
  logic [2*WIDTH-1:0]   w_jk_first;
  logic [2*WIDTH-1:0]   w_jk_next;

  // Map a base phase to packed {j, k}. Phase code bit 0 is J, bit 1 is K;
  // in walking mode channel i runs (p + i) mod 4, which the 2-bit add wraps.
  function automatic logic [2*WIDTH-1:0] f_drive(input logic [1:0] p,
                                                 input logic       walk);
    logic [WIDTH-1:0] fj;
    logic [WIDTH-1:0] fk;
    logic [1:0]       ph;
    fj = '0;
    fk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ph    = walk ? (p + 2'(i)) : p;
      fj[i] = ph[0];
      fk[i] = ph[1];
    end
    return {fj, fk};
  endfunction

  assign w_dwell_last = (r_dwell == DWELL_LAST);
  assign w_toggle_end = w_dwell_last && (r_p == 2'b11);
  assign w_seq_end    = w_toggle_end && (r_loop == LOOP_LAST);
  assign w_p_next     = w_dwell_last ? (r_p + 2'b01) : r_p;
  // First phase uses the live mode input since it is being latched this edge.
  assign w_jk_first   = f_drive(2'b00, mode);
  assign w_jk_next    = f_drive(w_p_next, r_mode);

  // Control FSM with registered j/k/handshake outputs and the golden JK model.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p     <= 2'b00;
      r_dwell <= '0;
      r_loop  <= '0;
      r_mode  <= 1'b0;
      r_j     <= '0;
      r_k     <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Golden JK: reacts to the j/k presently driven, so it trails them by a cycle.
      r_q <= (r_j & ~r_q) | (~r_k & r_q);
      case (r_state)
        S_IDLE: begin
          r_j    <= '0;
          r_k    <= '0;
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_p     <= 2'b00;
            r_dwell <= '0;
            r_loop  <= '0;
            r_mode  <= mode;
            r_j     <= w_jk_first[2*WIDTH-1:WIDTH];
            r_k     <= w_jk_first[WIDTH-1:0];
          end
        end
        S_RUN: begin
          if (w_seq_end) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_p     <= 2'b00;
            r_dwell <= '0;
            r_loop  <= '0;
            r_j     <= '0;
            r_k     <= '0;
          end else begin
            r_dwell <= w_dwell_last ? '0 : (r_dwell + DW_ONE);
            if (w_toggle_end) begin
              r_loop <= r_loop + LP_ONE;
            end
            r_p <= w_p_next;
            r_j <= w_jk_next[2*WIDTH-1:WIDTH];
            r_k <= w_jk_next[WIDTH-1:0];
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_j     <= '0;
          r_k     <= '0;
        end
      endcase
    end
  end

  assign j     = r_j;
  assign k     = r_k;
  assign q_exp = r_q;
  assign phase = r_p;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
